hazard_ctrl: RTL
================

# hazard_ctrl

Parametrised hazard controller for the 5-stage pipelined core. It resolves RAW hazards by forwarding or stalling, flushes on taken branches and jumps, and freezes the pipeline while a multi-cycle data memory holds off a request. Forwarding can be switched off by a mode parameter, and saturating counters record stall and flush activity. It drives the stall, flush and forward-select inputs of the pipelined datapath.

## Interface
- REG_ADDR_WIDTH, 5: register index width.
- FWD_EN, 1: 1 = forward from M/W; 0 = stall on every RAW hazard against E/M.
- MEM_TIMEOUT, 64: wait cycles before `mem_timeout` is set; 0 disables the timeout.
- CNT_W, 32: performance counter width.
- clk in 1: the only clock.
- reset in 1: synchronous, active-high.
- Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW in REG_ADDR_WIDTH each: stage register indices.
- RegWriteE, RegWriteM, RegWriteW in 1 each: writeback enables per stage.
- ResultSrcE0 in 1: the E instruction is a load.
- PCSrcE in 1: taken branch or jump resolved in E.
- MemReqM in 1: load or store in M.
- MemReadyM in 1: data memory completes the M access this cycle.
- StallF, StallD, StallE, StallM out 1 each: hold the PC register and the D/E/M pipeline registers.
- FlushD, FlushE, FlushW out 1 each: bubble into D, E, W.
- ForwardAE, ForwardBE out 2 each: 00 = regfile, 01 = ResultW, 10 = ALUResultM.
- stall_cnt, flush_cnt out CNT_W each: saturating event counters.
- mem_timeout out 1: sticky timeout flag.

## Operation
- match(rs, rd, we) = we & (rd != 0) & (rd == rs).
- Forwarding when FWD_EN=1, per source operand:
  - ForwardAE = 10 if match(Rs1E, RdM, RegWriteM).
  - Else ForwardAE = 01 if match(Rs1E, RdW, RegWriteW).
  - Else ForwardAE = 00.
  - ForwardBE is the same, using Rs2E.
  - M has priority over W.
- When FWD_EN=0, both forward selects are constant 00.
- rawStall:
  - FWD_EN=1: ResultSrcE0 & (match(Rs1D, RdE, RegWriteE) | match(Rs2D, RdE, RegWriteE)).
  - FWD_EN=0: any match of Rs1D or Rs2D against (RdE, RegWriteE) or (RdM, RegWriteM).
  - The regfile is write-before-read, so W needs no check.
- memStall = MemReqM & ~MemReadyM.
- Priority, highest first:
  - memStall: StallF, StallD, StallE and StallM = 1; FlushW = 1; FlushD and FlushE = 0. PCSrcE is ignored while memStall is high and is acted on in the release cycle, because E is held.
  - PCSrcE: FlushD = 1 and FlushE = 1.
  - rawStall: StallF = 1, StallD = 1, FlushE = 1.
- PCSrcE and a load in E never coincide, so the PCSrcE and FWD_EN=1 rawStall rules cannot conflict.
- Memory FSM, state type mem_state_t:
  - IDLE → WAIT when memStall.
  - WAIT → IDLE when MemReadyM.
  - wait_cnt counts cycles spent in WAIT and clears on entry to IDLE.
  - In WAIT, when wait_cnt == MEM_TIMEOUT-1 and MEM_TIMEOUT != 0, set mem_timeout. It stays set until reset. The stall continues.
- Counters, both saturating at 2^CNT_W−1:
  - stall_cnt += 1 on every cycle with StallF = 1.
  - flush_cnt += 1 on every cycle in which FlushD is asserted because of PCSrcE.
- Reset:
  - FSM goes to IDLE; wait_cnt, stall_cnt and flush_cnt go to 0; mem_timeout goes to 0.
  - While reset is high, outputs are forced: FlushD, FlushE, FlushW = 1; all stalls = 0; forwards = 00.
  - A reset during WAIT abandons the wait; the FSM is IDLE on the next cycle.

## Timing
- Stall, flush and forward outputs are combinational from the current inputs; there is no added latency.
- Counters and FSM update on the rising edge of clk.
- The counter value changes in the cycle after the triggering event.
- Release from WAIT: in the cycle MemReadyM = 1, all stalls drop and M advances on that edge.
- A memory wait of k cycles produces exactly k stalled cycles and k bubbles in W.
- A load-use hazard produces exactly one stall cycle when FWD_EN=1.
- With FWD_EN=0:
  - A dependence on the E instruction gives 2 stall cycles.
  - A dependence on the M instruction gives 1 stall cycle.
  - Both counts are extended by any memory wait.

## Structure
- types_pkg additions:
  - fwd_sel_t enum: FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10.
  - mem_state_t enum: IDLE, WAIT.
- Reuses the existing reg_addr_t.
- Sub-module sat_counter #(W): inputs clk, reset, inc; output count.
  - Instantiated twice: stall_cnt and flush_cnt.

## Test plan
- Load-use hazard:
  - Stimulus: FWD_EN=1; E holds a load with RdE=5, RegWriteE=1, ResultSrcE0=1; Rs1D=5.
  - Response: StallF=StallD=FlushE=1 for 1 cycle; then, with the load in M, ForwardAE=01 on the following cycle.
- Forward priority:
  - Stimulus: RdM=RdW=7, both RegWrite=1, Rs2E=7.
  - Response: ForwardBE=10. With RdM=0 the same case gives ForwardBE=01.
- Taken branch:
  - Stimulus: PCSrcE=1.
  - Response: FlushD=FlushE=1 and no stalls; flush_cnt increments from 0 to 1 on the next edge.
- Memory wait:
  - Stimulus: MemReqM=1 with MemReadyM low for 3 cycles; PCSrcE=1 throughout.
  - Response: all four stalls and FlushW high for 3 cycles with FlushD=0; in the release cycle FlushD=FlushE=1; stall_cnt=3.
- Timeout and reset:
  - Stimulus 1: MEM_TIMEOUT=4, MemReadyM held low for 10 cycles.
  - Response 1: mem_timeout rises after the 4th wait cycle and stays high.
  - Stimulus 2: assert reset in the middle of the wait.
  - Response 2: FSM is IDLE, mem_timeout=0, all counters 0.
- No-forward mode:
  - Stimulus: FWD_EN=0; an ALU writer with RdE=3 is followed by Rs1D=3.
  - Response: 2 stall cycles; ForwardAE stays 00 throughout.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard controller and its helpers.
// No logic: typedefs and constants only.
// No flow control.
package hazard_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // Operand source select for the E-stage ALU inputs.
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    // Data-memory handshake tracking.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter: counts cycles with inc high, sticks at all-ones.
// Latency: count reflects an event on the edge after it.
// No backpressure; inc is sampled every cycle.
module sat_counter
    import hazard_ctrl_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Increment on each event, holding at the maximum value.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: forwarding, load-use/RAW stalls, branch flushes, memory freeze.
// Latency: stall/flush/forward outputs are combinational; counters and timeout update next edge.
// Backpressure: a pending data-memory access freezes every stage and bubbles W until ready.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter bit FWD_EN         = 1'b1,
    parameter int MEM_TIMEOUT    = 64,
    parameter int CNT_W          = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
    input  logic [REG_ADDR_WIDTH-1:0] RdE,
    input  logic [REG_ADDR_WIDTH-1:0] RdM,
    input  logic [REG_ADDR_WIDTH-1:0] RdW,
    input  logic                      RegWriteE,
    input  logic                      RegWriteM,
    input  logic                      RegWriteW,
    input  logic                      ResultSrcE0,
    input  logic                      PCSrcE,
    input  logic                      MemReqM,
    input  logic                      MemReadyM,
    output logic                      StallF,
    output logic                      StallD,
    output logic                      StallE,
    output logic                      StallM,
    output logic                      FlushD,
    output logic                      FlushE,
    output logic                      FlushW,
    output logic [1:0]                ForwardAE,
    output logic [1:0]                ForwardBE,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          flush_cnt,
    output logic                      mem_timeout
);

    // Wide enough to reach MEM_TIMEOUT; saturates so it never wraps back onto the trigger value.
    localparam int WCW = $clog2(MEM_TIMEOUT + 1) + 1;

    // Register 0 is hardwired to zero, so a write to it never creates a dependence.
    function automatic logic regMatch(input logic [REG_ADDR_WIDTH-1:0] rs,
                                      input logic [REG_ADDR_WIDTH-1:0] rd,
                                      input logic                      we);
        return we && (rd != '0) && (rd == rs);
    endfunction

    fwd_sel_t         fwdA;
    fwd_sel_t         fwdB;
    logic             rawStall;
    logic             memStall;
    logic             branchFlush;
    mem_state_t       state;
    mem_state_t       nextState;
    logic [WCW-1:0]   waitCnt;
    logic [WCW-1:0]   nextWaitCnt;
    logic             timeoutHit;

    assign memStall = MemReqM && !MemReadyM;

    // Operand forwarding select; the younger M result wins over W.
    always_comb begin
        fwdA = FWD_RF;
        fwdB = FWD_RF;
        if (FWD_EN) begin
            if (regMatch(Rs1E, RdM, RegWriteM))      fwdA = FWD_M;
            else if (regMatch(Rs1E, RdW, RegWriteW)) fwdA = FWD_W;
            if (regMatch(Rs2E, RdM, RegWriteM))      fwdB = FWD_M;
            else if (regMatch(Rs2E, RdW, RegWriteW)) fwdB = FWD_W;
        end
    end

    // RAW detection on the D operands; W is covered by the write-before-read regfile.
    always_comb begin
        rawStall = 1'b0;
        if (FWD_EN) begin
            rawStall = ResultSrcE0 &&
                       (regMatch(Rs1D, RdE, RegWriteE) || regMatch(Rs2D, RdE, RegWriteE));
        end else begin
            rawStall = regMatch(Rs1D, RdE, RegWriteE) || regMatch(Rs2D, RdE, RegWriteE) ||
                       regMatch(Rs1D, RdM, RegWriteM) || regMatch(Rs2D, RdM, RegWriteM);
        end
    end

    // Stall/flush arbitration: reset, then memory freeze, then branch, then RAW stall.
    always_comb begin
        StallF      = 1'b0;
        StallD      = 1'b0;
        StallE      = 1'b0;
        StallM      = 1'b0;
        FlushD      = 1'b0;
        FlushE      = 1'b0;
        FlushW      = 1'b0;
        ForwardAE   = fwdA;
        ForwardBE   = fwdB;
        branchFlush = 1'b0;
        if (reset) begin
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            FlushW    = 1'b1;
            ForwardAE = FWD_RF;
            ForwardBE = FWD_RF;
        end else if (memStall) begin
            // E is frozen, so a branch resolved there is acted on in the release cycle.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (PCSrcE) begin
            FlushD      = 1'b1;
            FlushE      = 1'b1;
            branchFlush = 1'b1;
        end else if (rawStall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    // Memory wait FSM next state; waitCnt holds the number of stalled cycles so far.
    always_comb begin
        nextState   = state;
        nextWaitCnt = waitCnt;
        timeoutHit  = 1'b0;
        case (state)
            IDLE: begin
                if (memStall) begin
                    nextState   = WAIT;
                    nextWaitCnt = WCW'(1);
                    timeoutHit  = (MEM_TIMEOUT == 1);
                end else begin
                    nextWaitCnt = '0;
                end
            end
            WAIT: begin
                if (MemReadyM) begin
                    nextState   = IDLE;
                    nextWaitCnt = '0;
                end else begin
                    if (waitCnt != '1) nextWaitCnt = waitCnt + 1'b1;
                    timeoutHit = (MEM_TIMEOUT != 0) && (waitCnt == WCW'(MEM_TIMEOUT - 1));
                end
            end
            default: begin
                nextState   = IDLE;
                nextWaitCnt = '0;
            end
        endcase
    end

    // FSM state, wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            waitCnt     <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state   <= nextState;
            waitCnt <= nextWaitCnt;
            if (timeoutHit) mem_timeout <= 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) stallCounter (
        .clk   (clk),
        .reset (reset),
        .inc   (StallF),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) flushCounter (
        .clk   (clk),
        .reset (reset),
        .inc   (branchFlush),
        .count (flush_cnt)
    );

endmodule
